// File: rtl/ds1302_write.sv
// DS1302 time/date writer: clears write-protect, writes the seven clock registers from a
// snapshot taken at start, then optionally re-arms write-protect. Shares sclk/ce/dsData with the read path.
module ds1302_write #(
    parameter bit SET_WP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sclk,
    output logic       ce,
    inout  wire        dsData,
    input  logic [7:0] secData,
    input  logic [7:0] minData,
    input  logic [7:0] hrsData,
    input  logic [7:0] dateData,
    input  logic [7:0] monData,
    input  logic [7:0] dayData,
    input  logic [7:0] yrData,
    output logic       busy,
    output logic       done
);
    // state    | meaning
    // IDLE     | waiting for en
    // LOAD     | select {data, cmd} for tx_idx, wait for sclk steadily high
    // CE_SETUP | ce high, bit 0 on the line, wait for sclk falling
    // SHIFT_L  | present current bit, wait for sclk rising (DS1302 samples)
    // SHIFT_H  | hold bit, wait for sclk falling, then shift or end window
    // CE_LOW   | ce low, line released, wait for sclk rising
    // CE_GAP   | wait for sclk falling to complete a full idle period
    // NEXT     | advance to next transaction or finish
    // DONE     | one-cycle done pulse
    typedef enum logic [3:0] {
        IDLE, LOAD, CE_SETUP, SHIFT_L, SHIFT_H, CE_LOW, CE_GAP, NEXT, DONE
    } state_t;

    localparam logic [3:0] LAST_IDX = SET_WP ? 4'd8 : 4'd7;

    state_t      state_q, state_d;
    logic        sclk_q, sclk_d;
    logic        ce_q, ce_d;
    logic        io_dir_q, io_dir_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  tx_idx_q, tx_idx_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [55:0] snap_q, snap_d;

    logic        sclk_rising, sclk_falling;
    logic [7:0]  tx_cmd, tx_data;

    assign sclk_rising  = sclk & ~sclk_q;
    assign sclk_falling = ~sclk & sclk_q;

    assign ce     = ce_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign dsData = io_dir_q ? shift_q[0] : 1'bz;

    always_comb begin
        tx_cmd  = 8'h8E;
        tx_data = 8'h00;
        case (tx_idx_q)
            4'd1: begin tx_cmd = 8'h80; tx_data = snap_q[7:0];   end
            4'd2: begin tx_cmd = 8'h82; tx_data = snap_q[15:8];  end
            4'd3: begin tx_cmd = 8'h84; tx_data = snap_q[23:16]; end
            4'd4: begin tx_cmd = 8'h86; tx_data = snap_q[31:24]; end
            4'd5: begin tx_cmd = 8'h88; tx_data = snap_q[39:32]; end
            4'd6: begin tx_cmd = 8'h8A; tx_data = snap_q[47:40]; end
            4'd7: begin tx_cmd = 8'h8C; tx_data = snap_q[55:48]; end
            4'd8: begin tx_cmd = 8'h8E; tx_data = 8'h80;         end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sclk_d    = sclk;
        ce_d      = ce_q;
        io_dir_d  = io_dir_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tx_idx_d  = tx_idx_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        snap_d    = snap_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    // CH bit cleared so the oscillator runs after the write
                    snap_d   = {yrData, dayData, monData, dateData, hrsData, minData,
                                1'b0, secData[6:0]};
                    tx_idx_d = 4'd0;
                    busy_d   = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                shift_d   = {tx_data, tx_cmd};
                bit_cnt_d = 4'd0;
                // Raising ce only while sclk is steadily high guarantees the next edge seen
                // in CE_SETUP is a falling one, so no stray rising edge lands in the window.
                if (sclk && sclk_q) begin
                    ce_d     = 1'b1;
                    io_dir_d = 1'b1;
                    state_d  = CE_SETUP;
                end
            end
            CE_SETUP: if (sclk_falling) state_d = SHIFT_L;
            SHIFT_L:  if (sclk_rising)  state_d = SHIFT_H;
            SHIFT_H: begin
                if (sclk_falling) begin
                    if (bit_cnt_q == 4'd15) begin
                        ce_d     = 1'b0;
                        io_dir_d = 1'b0;
                        state_d  = CE_LOW;
                    end else begin
                        shift_d   = {1'b0, shift_q[15:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = SHIFT_L;
                    end
                end
            end
            CE_LOW: if (sclk_rising)  state_d = CE_GAP;
            CE_GAP: if (sclk_falling) state_d = NEXT;
            NEXT: begin
                if (tx_idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    tx_idx_d = tx_idx_q + 4'd1;
                    state_d  = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sclk_q    <= 1'b0;
            ce_q      <= 1'b0;
            io_dir_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_idx_q  <= 4'd0;
            bit_cnt_q <= 4'd0;
            shift_q   <= 16'd0;
            snap_q    <= 56'd0;
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_d;
            ce_q      <= ce_d;
            io_dir_q  <= io_dir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tx_idx_q  <= tx_idx_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            snap_q    <= snap_d;
        end
    end
endmodule

// File: tb/tb_ds1302_write.sv
// Directed bench for ds1302_write: a DS1302-side capture model decodes each ce window,
// with SET_WP=1 and SET_WP=0 instances exercised one after the other.
module tb_ds1302_write;
    logic       clk, rst, sclk, en1, en0;
    logic [7:0] sec, mn, hrs, date, mon, day, yr;
    wire        ds1, ds0;
    logic       ce1, ce0, busy1, busy0, done1, done0;

    int checks = 0;
    int failures = 0;

    ds1302_write #(.SET_WP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .sclk(sclk), .ce(ce1), .dsData(ds1),
        .secData(sec), .minData(mn), .hrsData(hrs), .dateData(date),
        .monData(mon), .dayData(day), .yrData(yr), .busy(busy1), .done(done1)
    );

    ds1302_write #(.SET_WP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .sclk(sclk), .ce(ce0), .dsData(ds0),
        .secData(sec), .minData(mn), .hrsData(hrs), .dateData(date),
        .monData(mon), .dayData(day), .yrData(yr), .busy(busy0), .done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sclk = clk/8, edges offset from clk edges
    initial begin
        sclk = 1'b0;
        #2;
        forever #40 sclk = ~sclk;
    end

    // The two instances are never active together, so one slave model watches both.
    wire ce_m = ce1 | ce0;
    wire ds_m = ce1 ? ds1 : ds0;

    logic [15:0] word, seq;
    int          rises;
    logic [15:0] wq[$];
    logic [15:0] sq[$];
    int          rq[$];

    always @(posedge ce_m) begin
        word  = 16'h0;
        seq   = 16'h0;
        rises = 0;
    end
    always @(posedge sclk) begin
        if (ce_m) begin
            word = {ds_m, word[15:1]};
            seq  = {seq[14:0], ds_m};
            rises++;
        end
    end
    always @(negedge ce_m) begin
        wq.push_back(word);
        sq.push_back(seq);
        rq.push_back(rises);
    end

    int  bus_err = 0;
    int  d1_cnt = 0;
    int  d0_cnt = 0;
    time last_fall = 0, last_chg = 0, last_rise = 0, min_gap = 1000000;

    always @(negedge clk) begin
        if (!ce1 && ds1 !== 1'bz) bus_err++;
        if (!ce0 && ds0 !== 1'bz) bus_err++;
        if (done1) d1_cnt++;
        if (done0) d0_cnt++;
    end
    always @(negedge ce_m) last_fall = $time;
    always @(posedge ce_m) begin
        if (last_fall != 0 && ($time - last_fall) < min_gap) min_gap = $time - last_fall;
    end
    always @(ds_m) begin
        if (ce_m) begin
            last_chg = $time;
            if ($time - last_rise <= 10) bus_err++;
        end
    end
    always @(posedge sclk) begin
        if (ce_m) begin
            last_rise = $time;
            if ($time - last_chg <= 10) bus_err++;
        end
    end

    logic [15:0] exp_w [9];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit which);
        @(negedge clk);
        if (which) en1 = 1'b1;
        else       en0 = 1'b1;
        @(negedge clk);
        en1 = 1'b0;
        en0 = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int max_cyc, output int busy_low);
        int n = 0;
        busy_low = 0;
        while (n < max_cyc && !(which ? done1 : done0)) begin
            @(negedge clk);
            n++;
            if (!(which ? done1 : done0) && !(which ? busy1 : busy0)) busy_low++;
        end
        check("done_seen", 32'(n < max_cyc), 32'd1);
    endtask

    task automatic check_words(input string tag, input int n);
        logic [15:0] got;
        int          r;
        check({tag, "_count"}, 32'(wq.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            got = (i < wq.size()) ? wq[i] : 16'hDEAD;
            r   = (i < rq.size()) ? rq[i] : -1;
            check($sformatf("%s_word%0d", tag, i), 32'(got), 32'(exp_w[i]));
            check($sformatf("%s_rises%0d", tag, i), 32'(r), 32'd16);
        end
    endtask

    task automatic clear_model();
        wq.delete();
        sq.delete();
        rq.delete();
    endtask

    initial begin
        int bl, n, dsave;
        rst = 1'b1; en1 = 1'b0; en0 = 1'b0;
        sec = 8'hD9; mn = 8'h30; hrs = 8'h12; date = 8'h25; mon = 8'h12; day = 8'h03; yr = 8'h24;
        repeat (2) @(negedge clk);
        check("rst_ce", 32'(ce1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_ds_z", 32'(ds1 === 1'bz), 32'd1);
        rst = 1'b0;

        // Full write with CH set in the input, inputs changed and en re-pulsed mid-write
        pulse(1'b1);
        repeat (400) @(negedge clk);
        check("busy_mid", 32'(busy1), 32'd1);
        sec = 8'h11; mn = 8'h22; hrs = 8'h05; date = 8'h06; mon = 8'h07; day = 8'h01; yr = 8'h55;
        pulse(1'b1);
        wait_done(1'b1, 3000, bl);
        check("run1_busy_gap", 32'(bl), 32'd0);
        repeat (300) @(negedge clk);
        check("run1_done_cnt", 32'(d1_cnt), 32'd1);
        exp_w = '{16'h008E, 16'h5980, 16'h3082, 16'h1284, 16'h2586,
                  16'h1288, 16'h038A, 16'h248C, 16'h808E};
        check_words("run1", 9);
        check("run1_sec_bits", 32'((sq.size() > 1) ? sq[1] : 16'hDEAD), 32'h019A);

        // Reset during the fifth bit of the hours write
        clear_model();
        sec = 8'h87; mn = 8'h45; hrs = 8'h23; date = 8'h31; mon = 8'h01; day = 8'h07; yr = 8'h99;
        pulse(1'b1);
        n = 0;
        while (n < 3000 && !(wq.size() == 3 && ce1 && rises == 4)) begin
            @(negedge clk);
            n++;
        end
        check("rst_trigger_seen", 32'(n < 3000), 32'd1);
        repeat (5) @(negedge clk);
        dsave = d1_cnt;
        rst = 1'b1;
        #1;
        check("midrst_ce", 32'(ce1), 32'd0);
        check("midrst_ds_z", 32'(ds1 === 1'bz), 32'd1);
        check("midrst_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("midrst_no_done", 32'(d1_cnt), 32'(dsave));
        check("midrst_windows", 32'(wq.size()), 32'd4);

        clear_model();
        pulse(1'b1);
        wait_done(1'b1, 3000, bl);
        check("run2_busy_gap", 32'(bl), 32'd0);
        repeat (300) @(negedge clk);
        exp_w = '{16'h008E, 16'h0780, 16'h4582, 16'h2384, 16'h3186,
                  16'h0188, 16'h078A, 16'h998C, 16'h808E};
        check_words("run2", 9);

        // SET_WP=0 instance: stops after the year write
        clear_model();
        sec = 8'h00; mn = 8'h01; hrs = 8'h02; date = 8'h03; mon = 8'h04; day = 8'h05; yr = 8'h06;
        pulse(1'b0);
        wait_done(1'b0, 3000, bl);
        check("run3_busy_gap", 32'(bl), 32'd0);
        repeat (300) @(negedge clk);
        check("run3_done_cnt", 32'(d0_cnt), 32'd1);
        exp_w = '{16'h008E, 16'h0080, 16'h0182, 16'h0284, 16'h0386,
                  16'h0488, 16'h058A, 16'h068C, 16'h0000};
        check_words("run3", 8);

        check("bus_discipline", 32'(bus_err), 32'd0);
        check("ce_gap_min", 32'(min_gap >= 80), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
